// File: rtl/isp_stream_pkg.sv
// Shared widths and defaults for the ISP pixel stream blocks.
// Also holds the word-to-pixel half selector.
package isp_stream_pkg;

   localparam int PIX_W        = 16;
   localparam int WORD_W       = 32;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef logic [PIX_W-1:0]  pix_t;
   typedef logic [WORD_W-1:0] word_t;

   function automatic pix_t word_half(input word_t w, input logic hi);
      return hi ? w[WORD_W-1:PIX_W] : w[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/word_skid_buf.sv
// Two-entry word buffer between the FIFO read port and the pixel splitter.
// Push and pop may occur in the same cycle; clr empties it at once.
module word_skid_buf
   import isp_stream_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic       pop,
   input  word_t      din,
   output word_t      head,
   output logic [1:0] occ
);

   word_t mem [2];
   logic  rd_ptr;
   logic  wr_ptr;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !(rst || clr))
         mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/read_fifo_unpacker.sv
// Pops 32-bit words from the read FIFO and streams RGB565 pixels with x/y flags.
// Define HALF_SWAP_EN to emit [31:16] before [15:0] within each word.
module read_fifo_unpacker
   import isp_stream_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int XW       = 11,
   parameter int YW       = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] fifo_do,
   input  logic              fifo_empty,
   output logic              fifo_re,
   input  logic              frame_restart,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_sof,
   output logic              pix_eol,
   output logic              pix_eof,
   output logic              underrun
);

   logic          inflight;
   logic          half;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   word_t         head;
   logic [1:0]    occ;
   logic          xfer;
   logic          push;
   logic          pop;
   logic          sel_hi;
   logic          x_last;
   logic          y_last;

   assign pix_valid = (occ != 2'd0);

   // Reads in flight count against the two slots so a word never lands on a full buffer.
   assign fifo_re = !rst && !fifo_empty && !frame_restart
                 && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);

   assign xfer = pix_valid && pix_ready && !frame_restart;
   assign push = inflight && !frame_restart;
   assign pop  = xfer && half;

`ifdef HALF_SWAP_EN
   assign sel_hi = !half;
`else
   assign sel_hi = half;
`endif

   assign x_last = (x == XW'(H_ACTIVE - 1));
   assign y_last = (y == YW'(V_ACTIVE - 1));

   assign pix_data = pix_valid ? word_half(head, sel_hi) : '0;
   assign pix_sof  = pix_valid && (x == '0) && (y == '0);
   assign pix_eol  = pix_valid && x_last;
   assign pix_eof  = pix_eol && y_last;
   assign underrun = pix_ready && !pix_valid && !frame_restart
                  && ((x != '0) || (y != '0));

   always_ff @(posedge clk) begin
      if (rst || frame_restart) begin
         inflight <= 1'b0;
         half     <= 1'b0;
         x        <= '0;
         y        <= '0;
      end else begin
         inflight <= fifo_re;
         if (xfer) begin
            half <= ~half;
            if (x_last) begin
               x <= '0;
               y <= y_last ? '0 : y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
         end
      end
   end

   word_skid_buf u_buf (
      .clk  (clk),
      .rst  (rst),
      .clr  (frame_restart),
      .push (push),
      .pop  (pop),
      .din  (fifo_do),
      .head (head),
      .occ  (occ)
   );

endmodule

// File: tb/tb_read_fifo_unpacker.sv
// Bench for read_fifo_unpacker: FIFO model, pixel reference queue,
// a directed vector table and multi-cycle corner sequences.
module tb_read_fifo_unpacker;

   localparam int H = 4;
   localparam int V = 2;
   localparam int F = H * V;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fifo_do = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_re;
   logic        frame_restart;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_sof;
   logic        pix_eol;
   logic        pix_eof;
   logic        underrun;

   read_fifo_unpacker #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .XW       (11),
      .YW       (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_do       (fifo_do),
      .fifo_empty    (fifo_empty),
      .fifo_re       (fifo_re),
      .frame_restart (frame_restart),
      .pix_data      (pix_data),
      .pix_valid     (pix_valid),
      .pix_ready     (pix_ready),
      .pix_sof       (pix_sof),
      .pix_eol       (pix_eol),
      .pix_eof       (pix_eof),
      .underrun      (underrun)
   );

   initial forever #5 clk = ~clk;

   logic [31:0] fq [$];
   logic [15:0] exp_pix [$];

   // FIFO model: data one cycle after an accepted re, flag refreshed mid-cycle.
   always @(posedge clk) begin
      if (fifo_re && fq.size() > 0)
         fifo_do <= fq.pop_front();
   end

   always @(negedge clk) fifo_empty <= (fq.size() == 0);

   int n_chk = 0;
   int n_pass = 0;
   int idx = 0;
   bit prev_stall = 0;
   bit prev_clr = 0;
   logic [15:0] prev_data = '0;
   logic [2:0] obs [16];

   logic        s_valid, s_sof, s_eol, s_eof, s_re, s_ur, s_xfer;
   logic [15:0] s_data;

   function automatic logic [15:0] pix_of(input logic [31:0] w, input int k);
`ifdef HALF_SWAP_EN
      return (k == 0) ? w[31:16] : w[15:0];
`else
      return (k == 0) ? w[15:0] : w[31:16];
`endif
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a === e)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h", n, a, e);
   endtask

   task automatic pushw(input logic [31:0] w);
      fq.push_back(w);
      exp_pix.push_back(pix_of(w, 0));
      exp_pix.push_back(pix_of(w, 1));
   endtask

   // Words already pulled from the FIFO are lost on a clear.
   task automatic rebuild();
      exp_pix.delete();
      for (int i = 0; i < fq.size(); i++) begin
         exp_pix.push_back(pix_of(fq[i], 0));
         exp_pix.push_back(pix_of(fq[i], 1));
      end
      idx = 0;
   endtask

   task automatic cycle(input bit rdy, input bit rs, input bit rv);
      logic [15:0] e;
      pix_ready = rdy;
      frame_restart = rs;
      rst = rv;
      @(negedge clk);
      #1;
      s_valid = pix_valid;
      s_data  = pix_data;
      s_sof   = pix_sof;
      s_eol   = pix_eol;
      s_eof   = pix_eof;
      s_re    = fifo_re;
      s_ur    = underrun;
      s_xfer  = 1'b0;
      if (rv) begin
         chk("re_in_rst", fifo_re, 0);
      end else begin
         if (fifo_empty)
            chk("re_while_empty", fifo_re, 0);
         if (prev_clr)
            chk("valid_after_clear", pix_valid, 0);
         if (prev_stall) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_data", pix_data, prev_data);
         end
         chk("underrun", underrun, rdy && !pix_valid && !rs && (idx % F != 0));
         if (pix_valid && rdy && !rs) begin
            s_xfer = 1'b1;
            if (exp_pix.size() == 0) begin
               chk("extra_pixel", pix_valid, 0);
            end else begin
               e = exp_pix.pop_front();
               chk("pix_data", pix_data, e);
               chk("pix_sof", pix_sof, idx % F == 0);
               chk("pix_eol", pix_eol, idx % H == H - 1);
               chk("pix_eof", pix_eof, idx % F == F - 1);
               if (idx < 16)
                  obs[idx] = {pix_sof, pix_eol, pix_eof};
               idx++;
            end
         end
      end
      prev_stall = !rv && !rs && pix_valid && !rdy;
      prev_data = pix_data;
      prev_clr = rv || rs;
      if (rv || rs)
         rebuild();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      fq.delete();
      cycle(0, 0, 1);
      cycle(0, 0, 1);
   endtask

   typedef struct {
      bit          rdy;
      bit          v;
      logic [15:0] d;
      bit          sof;
      bit          eol;
      bit          eof;
      bit          re;
      bit          ur;
   } vec_t;

   vec_t tbl [7];
   int   re_cnt;
   int   ucnt;
   bit   got;

   localparam logic [31:0] W0 = 32'h2222_1111;
   localparam logic [31:0] W1 = 32'h4444_3333;

   initial begin
      tbl[0] = '{1, 0, 16'h0, 0, 0, 0, 1, 0};
      tbl[1] = '{1, 0, 16'h0, 0, 0, 0, 1, 0};
      tbl[2] = '{1, 1, pix_of(W0, 0), 1, 0, 0, 0, 0};
      tbl[3] = '{1, 1, pix_of(W0, 1), 0, 0, 0, 0, 0};
      tbl[4] = '{1, 1, pix_of(W1, 0), 0, 0, 0, 0, 0};
      tbl[5] = '{1, 1, pix_of(W1, 1), 0, 1, 0, 0, 0};
      tbl[6] = '{1, 0, 16'h0, 0, 0, 0, 0, 1};

      rst = 1'b1;
      pix_ready = 1'b0;
      frame_restart = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      cycle(0, 0, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_data", s_data, 0);
      chk("rst_sof", s_sof, 0);
      chk("rst_eol", s_eol, 0);
      chk("rst_eof", s_eof, 0);
      chk("rst_re", s_re, 0);
      chk("rst_underrun", s_ur, 0);

      // Two preloaded words, ready held high.
      pushw(W0);
      pushw(W1);
      re_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         cycle(tbl[i].rdy, 0, 0);
         chk("t_valid", s_valid, tbl[i].v);
         chk("t_data", s_data, tbl[i].d);
         chk("t_sof", s_sof, tbl[i].sof);
         chk("t_eol", s_eol, tbl[i].eol);
         chk("t_eof", s_eof, tbl[i].eof);
         chk("t_re", s_re, tbl[i].re);
         chk("t_underrun", s_ur, tbl[i].ur);
         re_cnt += int'(s_re);
      end
      chk("t_re_count", re_cnt, 2);

      // Frame boundaries with a 4x2 frame.
      do_reset();
      for (int i = 0; i < 16; i++) obs[i] = '0;
      for (int i = 0; i < 5; i++) pushw(32'h0100_0000 * (i + 1) + 32'h11 * i);
      repeat (16) cycle(1, 0, 0);
      chk("fr_eol3", obs[3][1], 1);
      chk("fr_eol7", obs[7][1], 1);
      chk("fr_eof3", obs[3][0], 0);
      chk("fr_eof7", obs[7][0], 1);
      chk("fr_sof4", obs[4][2], 0);
      chk("fr_sof8", obs[8][2], 1);
      chk("fr_drained", exp_pix.size(), 0);

      // Random source against random back-pressure.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (fq.size() < 6 && ($urandom % 4) != 0)
            pushw($urandom);
         cycle(1'($urandom % 2), ($urandom % 97) == 0, 0);
      end
      repeat (30) cycle(1, 0, 0);
      chk("rand_drained", exp_pix.size(), 0);

      // Underrun mid-line, then none between frames.
      do_reset();
      pushw(32'hBEEF_CAFE);
      ucnt = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1, 0, 0);
         ucnt += int'(s_ur);
      end
      chk("ur_midline", ucnt, 4);
      pushw(32'h0002_0001);
      pushw(32'h0004_0003);
      pushw(32'h0006_0005);
      ucnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1, 0, 0);
         ucnt += int'(s_ur);
      end
      chk("ur_frame_gap", ucnt, 2);

      // Restart the cycle after a read, with one word held.
      do_reset();
      pushw(32'hAAAA_5555);
      cycle(0, 0, 0);
      cycle(0, 0, 0);
      pushw(32'hDEAD_BEEF);
      cycle(0, 0, 0);
      chk("rs_pre_valid", s_valid, 1);
      chk("rs_pre_re", s_re, 1);
      cycle(0, 1, 0);
      chk("rs_re", s_re, 0);
      cycle(1, 0, 0);
      chk("rs_post_valid", s_valid, 0);
      pushw(32'h7777_6666);
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         cycle(1, 0, 0);
         if (s_xfer) begin
            got = 1;
            chk("rs_next_data", s_data, pix_of(32'h7777_6666, 0));
            chk("rs_next_sof", s_sof, 1);
         end
      end
      chk("rs_next_seen", got, 1);

      // Reset mid-frame with a pixel waiting.
      do_reset();
      pushw(32'h1234_5678);
      repeat (3) cycle(1, 0, 0);
      cycle(0, 0, 0);
      chk("mr_pre_valid", s_valid, 1);
      pushw(32'h9ABC_DEF0);
      cycle(0, 0, 1);
      cycle(1, 0, 0);
      chk("mr_valid", s_valid, 0);
      chk("mr_data", s_data, 0);
      chk("mr_sof", s_sof, 0);
      chk("mr_eol", s_eol, 0);
      chk("mr_eof", s_eof, 0);
      chk("mr_underrun", s_ur, 0);
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         cycle(1, 0, 0);
         if (s_xfer) begin
            got = 1;
            chk("mr_next_data", s_data, pix_of(32'h9ABC_DEF0, 0));
            chk("mr_next_sof", s_sof, 1);
         end
      end
      chk("mr_next_seen", got, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
